// File: rtl/painel_jogadores.sv
// Player LED panel: normal display of current/selected players, plus a timed
// blink announcement of an eliminated player with a done pulse.
module painel_jogadores #(
  parameter int unsigned N_JOGADORES  = 5,
  parameter int unsigned BLINK_CICLOS = 25000000,
  parameter int unsigned N_PISCADAS   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mostra,
  input  logic [2:0]             jogador_atual,
  input  logic [2:0]             jogador_escolhido,
  input  logic [N_JOGADORES-1:0] vivos,
  input  logic                   anuncia,
  input  logic [2:0]             eliminado,
  output logic [N_JOGADORES-1:0] leds,
  output logic                   ocupado,
  output logic                   fim_anuncio,
  output logic [1:0]             db_estado
);

  localparam int unsigned CW = $clog2(BLINK_CICLOS);
  localparam int unsigned PW = $clog2(N_PISCADAS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(BLINK_CICLOS - 1);
  localparam logic [PW-1:0] PARES_MAX = PW'(N_PISCADAS);

  typedef enum logic [1:0] {
    REPOUSO = 2'd0,
    ACESO   = 2'd1,
    APAGADO = 2'd2,
    FIM     = 2'd3
  } estado_t;

  estado_t                estado, estado_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   fase, fase_nxt;
  logic [PW-1:0]          pares, pares_nxt;
  logic [2:0]             idx, idx_nxt;
  logic [N_JOGADORES-1:0] leds_nxt;
  logic                   ocupado_nxt, fim_nxt;
  logic                   wrap;
  logic [N_JOGADORES-1:0] normal;

  function automatic logic [N_JOGADORES-1:0] um_quente(input logic [2:0] j);
    logic [N_JOGADORES-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_JOGADORES; i++) r[i] = (32'(j) == i);
    return r;
  endfunction

  assign wrap      = (cnt == CNT_MAX);
  assign db_estado = estado;

  // Idle display pattern; the solid current player takes priority over blinking.
  always_comb begin
    normal = '0;
    if (mostra) begin
      for (int unsigned i = 0; i < N_JOGADORES; i++) begin
        if (vivos[i]) begin
          if (32'(jogador_atual) == i)          normal[i] = 1'b1;
          else if (32'(jogador_escolhido) == i) normal[i] = fase;
        end
      end
    end
  end

  // Outputs are registered from the next state so LEDs line up with db_estado.
  always_comb begin
    estado_nxt  = estado;
    cnt_nxt     = wrap ? '0 : cnt + CW'(1);
    fase_nxt    = wrap ? ~fase : fase;
    pares_nxt   = pares;
    idx_nxt     = idx;
    leds_nxt    = '0;
    ocupado_nxt = 1'b1;
    fim_nxt     = 1'b0;
    case (estado)
      REPOUSO: begin
        ocupado_nxt = 1'b0;
        leds_nxt    = normal;
        if (anuncia) begin
          estado_nxt  = ACESO;
          idx_nxt     = eliminado;
          cnt_nxt     = '0;
          fase_nxt    = 1'b1;
          leds_nxt    = um_quente(eliminado);
          ocupado_nxt = 1'b1;
        end
      end
      ACESO: begin
        leds_nxt = um_quente(idx);
        if (wrap) begin
          estado_nxt = APAGADO;
          leds_nxt   = '0;
        end
      end
      APAGADO: begin
        if (wrap) begin
          pares_nxt = pares + PW'(1);
          if (pares + PW'(1) == PARES_MAX) begin
            estado_nxt = FIM;
            fim_nxt    = 1'b1;
          end else begin
            estado_nxt = ACESO;
            leds_nxt   = um_quente(idx);
          end
        end
      end
      FIM: begin
        estado_nxt  = REPOUSO;
        pares_nxt   = '0;
        ocupado_nxt = 1'b0;
        leds_nxt    = normal;
      end
      default: estado_nxt = REPOUSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= REPOUSO;
      cnt         <= '0;
      fase        <= 1'b0;
      pares       <= '0;
      idx         <= 3'd7;
      leds        <= '0;
      ocupado     <= 1'b0;
      fim_anuncio <= 1'b0;
    end else begin
      estado      <= estado_nxt;
      cnt         <= cnt_nxt;
      fase        <= fase_nxt;
      pares       <= pares_nxt;
      idx         <= idx_nxt;
      leds        <= leds_nxt;
      ocupado     <= ocupado_nxt;
      fim_anuncio <= fim_nxt;
    end
  end

endmodule

// File: tb/tb_painel_jogadores.sv
// Bench for painel_jogadores: directed scenarios plus random traffic checked
// every cycle against a cycle-index based reference model.
module tb_painel_jogadores;

  localparam int N  = 5;
  localparam int B  = 4;
  localparam int NP = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         mostra = 1'b0;
  logic         anuncia = 1'b0;
  logic [2:0]   atual = '0;
  logic [2:0]   escolhido = '0;
  logic [2:0]   eliminado = '0;
  logic [N-1:0] vivos = '0;
  logic [N-1:0] leds;
  logic         ocupado, fim_anuncio;
  logic [1:0]   db_estado;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: blink phase derived from edges since the last
  // timebase restart; announcement progress as a cycle index since acceptance.
  bit           in_reset;
  bit           m_busy;
  int           m_k;
  int           m_e;
  bit           m_base;
  int           m_idx;
  logic [N-1:0] x_leds;
  logic         x_ocup, x_fim;
  logic [1:0]   x_st;

  always #5 clock = ~clock;

  painel_jogadores #(
    .N_JOGADORES (N),
    .BLINK_CICLOS(B),
    .N_PISCADAS  (NP)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mostra           (mostra),
    .jogador_atual    (atual),
    .jogador_escolhido(escolhido),
    .vivos            (vivos),
    .anuncia          (anuncia),
    .eliminado        (eliminado),
    .leds             (leds),
    .ocupado          (ocupado),
    .fim_anuncio      (fim_anuncio),
    .db_estado        (db_estado)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int j);
    logic [N-1:0] r;
    r = '0;
    if (j >= 0 && j < N) r[j] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] display(input bit m, input logic [N-1:0] v,
                                           input int a, input int s, input bit p);
    logic [N-1:0] r;
    r = '0;
    if (m) begin
      for (int i = 0; i < N; i++) begin
        if (v[i] && a == i)      r[i] = 1'b1;
        else if (v[i] && s == i) r[i] = p;
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    bit p;
    p = m_base ^ (((m_e / B) % 2) == 1);
    if (in_reset) begin
      x_leds = '0; x_ocup = 1'b0; x_fim = 1'b0; x_st = 2'd0;
    end else if (!m_busy) begin
      if (anuncia) begin
        m_busy = 1'b1; m_k = 1; m_idx = int'(eliminado);
        m_e = 0; m_base = 1'b1;
        x_leds = onehot(m_idx); x_ocup = 1'b1; x_fim = 1'b0; x_st = 2'd1;
      end else begin
        m_e++;
        x_leds = display(mostra, vivos, int'(atual), int'(escolhido), p);
        x_ocup = 1'b0; x_fim = 1'b0; x_st = 2'd0;
      end
    end else begin
      m_e++;
      m_k++;
      if (m_k <= 2 * NP * B) begin
        bit on;
        on = (((m_k - 1) / B) % 2) == 0;
        x_st = on ? 2'd1 : 2'd2;
        x_leds = on ? onehot(m_idx) : '0;
        x_ocup = 1'b1; x_fim = 1'b0;
      end else if (m_k == 2 * NP * B + 1) begin
        x_st = 2'd3; x_fim = 1'b1; x_leds = '0; x_ocup = 1'b1;
      end else begin
        m_busy = 1'b0;
        x_st = 2'd0; x_fim = 1'b0; x_ocup = 1'b0;
        x_leds = display(mostra, vivos, int'(atual), int'(escolhido), p);
      end
    end
  endtask

  task automatic check_all();
    check("leds", 32'(leds), 32'(x_leds));
    check("ocupado", 32'(ocupado), 32'(x_ocup));
    check("fim_anuncio", 32'(fim_anuncio), 32'(x_fim));
    check("db_estado", 32'(db_estado), 32'(x_st));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  // Assert reset away from the clock edge and verify the asynchronous clear.
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    in_reset = 1'b1;
    m_busy = 1'b0; m_e = 0; m_base = 1'b0; m_k = 0;
    x_leds = '0; x_ocup = 1'b0; x_fim = 1'b0; x_st = 2'd0;
    #1;
    check_all();
    repeat (cycles) tick();
    reset = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic rand_inputs();
    mostra    = ($urandom_range(0, 3) != 0);
    vivos     = N'($urandom);
    atual     = 3'($urandom_range(0, 7));
    escolhido = 3'($urandom_range(0, 7));
  endtask

  initial begin
    // 1: reset with arbitrary inputs
    rand_inputs();
    eliminado = 3'($urandom_range(0, 7));
    do_reset(4);
    repeat (3) tick();

    // 2: normal display
    mostra = 1'b1; vivos = 5'b11111; atual = 3'd1; escolhido = 3'd3;
    repeat (12) tick();

    // 3: dead current player, then same current/selected player
    vivos = 5'b11101; atual = 3'd1;
    repeat (3) tick();
    vivos = 5'b11111; atual = 3'd2; escolhido = 3'd2;
    repeat (6) tick();

    // 4: announcement of player 4, inputs scrambled while busy
    anuncia = 1'b1; eliminado = 3'd4;
    tick();
    anuncia = 1'b0;
    for (int c = 0; c < 20; c++) begin
      rand_inputs();
      eliminado = 3'($urandom_range(0, 7));
      tick();
    end

    // 5: second request while busy, then an out-of-range index
    mostra = 1'b1; vivos = 5'b11111; atual = 3'd0; escolhido = 3'd4;
    anuncia = 1'b1; eliminado = 3'd2;
    tick();
    anuncia = 1'b0;
    repeat (5) tick();
    anuncia = 1'b1; eliminado = 3'd0;
    tick();
    anuncia = 1'b0;
    repeat (16) tick();
    anuncia = 1'b1; eliminado = 3'd6;
    tick();
    anuncia = 1'b0;
    repeat (20) tick();

    // 6: reset at cycle 6 of an announcement
    anuncia = 1'b1; eliminado = 3'd3;
    tick();
    anuncia = 1'b0;
    repeat (5) tick();
    do_reset(3);
    repeat (25) tick();

    // Random traffic with occasional requests and resets
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      anuncia   = ($urandom_range(0, 19) == 0);
      eliminado = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) do_reset(2);
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
